seq_det_scheduler: RTL and testbench

- Shares one bit-serial "1 after two-or-more 0s" detector among N word-parallel requesters.
- Round-robin arbiter grants one requester at a time and captures its W-bit word.
- The captured word is shifted MSB-first through the detector, which is cleared per word; the number of detections in the word is counted.
- The channel id and match count are returned on a valid/ready result port.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_core.sv | 35 +++
 rtl/seq_det_scheduler.sv | 103 ++++++++++
 tb/tb_seq_det_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared encodings for the shared sequence-detector scheduler.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial Mealy detector: z=1 on a 1 that follows two or more 0s.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    det_state_t st, st_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      st <= S0;
        else if (clr) st <= S0;
        else if (en)  st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (x) begin
            st_nxt = S0;
        end else begin
            case (st)
                S0:      st_nxt = S1;
                S1:      st_nxt = S2;
                default: st_nxt = S3;
            endcase
        end
        z = en && x && (st == S2 || st == S3);
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one seq_det_core among N word-parallel requesters;
// returns per-word detection counts on a valid/ready result port.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int CW = $clog2(N),
    localparam int KW = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    res_chan,
    output logic [KW-1:0]    res_count,
    output logic             match,
    output logic             busy
);

    ctrl_state_t          state, state_nxt;
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        grant;
    logic [CW-1:0]        idx;
    logic [N-1:0][W-1:0]  words;
    logic [W-1:0]         shreg;
    logic [KW-1:0]        bcnt;
    logic [KW-1:0]        cnt;
    logic                 hs;
    logic                 z;

    assign words = in_data;

    // Scan from the farthest slot back to rr_ptr so the closest valid wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = CW'((int'(rr_ptr) + k) % N);
            if (in_valid[idx]) grant = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (|in_valid) begin
                    hs        = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT:   if (bcnt == KW'(W - 1)) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        in_ready = (hs && !rst) ? (N'(1) << grant) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            shreg    <= '0;
            bcnt     <= '0;
            cnt      <= '0;
            res_chan <= '0;
        end else if (hs) begin
            shreg    <= words[grant];
            res_chan <= grant;
            rr_ptr   <= (grant == CW'(N - 1)) ? '0 : grant + 1'b1;
            bcnt     <= '0;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            bcnt  <= bcnt + 1'b1;
            if (z && cnt != KW'(W)) cnt <= cnt + 1'b1;
        end
    end

    seq_det_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (hs),
        .en  (state == SHIFT),
        .x   (shreg[W-1]),
        .z   (z)
    );

    assign match     = z;
    assign res_valid = (state == DONE);
    assign res_count = cnt;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: table-driven words plus reset and round-robin sequences.
module tb_seq_det_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;
    localparam int KW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           res_valid;
    logic           res_ready;
    logic [CW-1:0]  res_chan;
    logic [KW-1:0]  res_count;
    logic           match;
    logic           busy;

    int total  = 0;
    int passed = 0;

    typedef struct {
        int           chan;
        logic [W-1:0] data;
        logic [W-1:0] mask;   // data bits on which match must pulse
        int           count;
        int           hold;   // DONE cycles with res_ready low
    } vec_t;

    vec_t vecs[6];

    seq_det_scheduler #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_chan  (res_chan),
        .res_count (res_count),
        .match     (match),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_word(input int chan, input logic [W-1:0] data, input logic [W-1:0] mask,
                            input int count, input int hold);
        logic [W-1:0] seen;
        int           edges;
        bit           rdy_quiet;
        bit           stable;
        @(negedge clk);
        in_data              = '0;
        in_data[chan*W +: W] = data;
        in_valid             = '0;
        in_valid[chan]       = 1'b1;
        res_ready            = (hold == 0);
        #1 check($sformatf("grant_ch%0d", chan), in_ready, 32'(1) << chan);
        @(posedge clk);
        #1 in_valid = '0;
        seen      = '0;
        edges     = 0;
        rdy_quiet = 1'b1;
        @(negedge clk);
        while (!res_valid && edges < 4 * W) begin
            if (edges < W) seen[W-1-edges] = match;
            if (in_ready != '0) rdy_quiet = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", edges + 1, W + 1);
        check("res_chan", res_chan, chan);
        check("res_count", res_count, count);
        check("match_mask", seen, mask);
        check("ready_quiet_shift", rdy_quiet, 1);
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                if (!(res_valid && busy && res_chan == CW'(chan) && res_count == KW'(count)
                      && in_ready == '0)) stable = 1'b0;
            end
            check("backpressure_hold", stable, 1);
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("released_valid", res_valid, 0);
        check("released_busy", busy, 0);
    endtask

    initial begin
        logic [CW-1:0] order[5];
        int            edges;
        bit            rdy_quiet;
        bit            chan_ok;

        vecs[0] = '{0, 8'b00100100, 8'b00100100, 2, 0};
        vecs[1] = '{2, 8'b10001000, 8'b00001000, 1, 5};
        vecs[2] = '{1, 8'hFF,       8'h00,       0, 0};
        vecs[3] = '{3, 8'h00,       8'h00,       0, 0};
        vecs[4] = '{0, 8'b00000001, 8'b00000001, 1, 0};
        vecs[5] = '{0, 8'b10000000, 8'b00000000, 0, 0};
        order   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = '0;
        res_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_chan", res_chan, 0);
        check("rst_res_count", res_count, 0);
        check("rst_match", match, 0);
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_word(vecs[i].chan, vecs[i].data, vecs[i].mask, vecs[i].count, vecs[i].hold);

        // Reset in the 4th SHIFT cycle of a ch1 word; ch1 stays pending.
        @(negedge clk);
        in_data = {4{8'h55}};
        in_valid = 4'b0010;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst      = 1'b1;
        in_valid = 4'b0011;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_match", match, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_grant_ch0", in_ready, 4'b0001);

        // All requesters valid: grants rotate 0,1,2,3,0.
        in_valid = 4'b1111;
        in_data  = {8'h24, 8'h10, 8'h99, 8'h03};
        for (int g = 0; g < 5; g++) begin
            #1 check($sformatf("rr_grant_%0d", g), in_ready, 32'(1) << order[g]);
            @(posedge clk);
            edges     = 0;
            rdy_quiet = 1'b1;
            chan_ok   = 1'b0;
            do begin
                @(negedge clk);
                if (busy && in_ready != '0) rdy_quiet = 1'b0;
                if (res_valid && res_chan == order[g]) chan_ok = 1'b1;
                edges++;
            end while (busy && edges < 100);
            check($sformatf("rr_quiet_%0d", g), rdy_quiet, 1);
            check($sformatf("rr_chan_%0d", g), chan_ok, 1);
            check($sformatf("rr_done_%0d", g), busy, 0);
        end
        in_valid = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
